// File: rtl/shreg_universal.sv
// W-bit universal shift register with an automatic serialiser FSM.
// Modes in IDLE: hold, shift right, shift left, parallel load.
// A START pulse loads Ip and then shifts it out through So, one bit per
// enabled falling edge of C, and raises BUSY for the transfer and DONE for one clock.
// Optional feature macro: SHREG_ROTATE_EN adds the ROT input. With ROT=1 the
// fill bit is the bit shifted out, so the register rotates.
module shreg_universal #(
    parameter int W         = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         C,
    input  logic         CLR,
    input  logic         CE,
    input  logic [1:0]   M,
    input  logic         Is,
    input  logic [W-1:0] Ip,
    input  logic         START,
`ifdef SHREG_ROTATE_EN
    input  logic         ROT,
`endif
    output logic [W-1:0] O,
    output logic         So,
    output logic         BUSY,
    output logic         DONE
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_o;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic          w_rot;
    logic          w_fill_r;
    logic          w_fill_l;
    logic [W-1:0]  w_shr;
    logic [W-1:0]  w_shl;
    logic [W-1:0]  w_xfer_next;

`ifdef SHREG_ROTATE_EN
    assign w_rot = ROT;
`else
    assign w_rot = 1'b0;
`endif

    // Fill bit is Is, or the bit falling off the opposite end when rotating
    assign w_fill_r    = w_rot ? r_o[0]   : Is;
    assign w_fill_l    = w_rot ? r_o[W-1] : Is;
    assign w_shr       = {w_fill_r, r_o[W-1:1]};
    assign w_shl       = {r_o[W-2:0], w_fill_l};
    assign w_xfer_next = MSB_FIRST ? w_shl : w_shr;

    // Register, counter and FSM; DONE self-clears on every edge regardless of CE
    always_ff @(negedge C or posedge CLR) begin
        if (CLR) begin
            r_state <= S_IDLE;
            r_o     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (CE) begin
                case (r_state)
                    S_IDLE: begin
                        if (START) begin
                            r_o     <= Ip;
                            r_cnt   <= CNT_INIT;
                            r_state <= S_XFER;
                            r_busy  <= 1'b1;
                        end else begin
                            case (M)
                                2'b01:   r_o <= w_shr;
                                2'b10:   r_o <= w_shl;
                                2'b11:   r_o <= Ip;
                                default: r_o <= r_o;
                            endcase
                        end
                    end
                    S_XFER: begin
                        r_o   <= w_xfer_next;
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign O    = r_o;
    assign So   = MSB_FIRST ? r_o[W-1] : r_o[0];
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule

// File: tb/tb_shreg_universal.sv
// Bench for shreg_universal (W=4): one LSB-first and one MSB-first instance
// share every input. Directed scenarios and a randomized run, the latter
// checked against a behavioural model. Rotation scenarios need SHREG_ROTATE_EN.
module tb_shreg_universal;

    localparam int W = 4;

    logic         C = 1'b1;
    logic         CLR = 1'b1;
    logic         CE = 1'b0;
    logic [1:0]   M = 2'b00;
    logic         Is = 1'b0;
    logic [W-1:0] Ip = '0;
    logic         START = 1'b0;
    logic         ROT = 1'b0;

    logic [W-1:0] O0, O1;
    logic         So0, So1, B0, B1, D0, D1;

    int nvec = 0;
    int nerr = 0;

    // behavioural model state, index 0 = LSB first, 1 = MSB first
    int mo[2];
    int mrem[2];
    bit mbusy[2];
    bit mdone[2];

    always #5 C = ~C;

    shreg_universal #(.W(W), .MSB_FIRST(1'b0)) dut_l (
        .C(C), .CLR(CLR), .CE(CE), .M(M), .Is(Is), .Ip(Ip), .START(START),
`ifdef SHREG_ROTATE_EN
        .ROT(ROT),
`endif
        .O(O0), .So(So0), .BUSY(B0), .DONE(D0)
    );

    shreg_universal #(.W(W), .MSB_FIRST(1'b1)) dut_m (
        .C(C), .CLR(CLR), .CE(CE), .M(M), .Is(Is), .Ip(Ip), .START(START),
`ifdef SHREG_ROTATE_EN
        .ROT(ROT),
`endif
        .O(O1), .So(So1), .BUSY(B1), .DONE(D1)
    );

    function automatic int rot_on();
`ifdef SHREG_ROTATE_EN
        return int'(ROT);
`else
        return 0;
`endif
    endfunction

    function automatic int sh_right(int v, int fill);
        return (v / 2) + fill * (1 << (W - 1));
    endfunction

    function automatic int sh_left(int v, int fill);
        return (v * 2 + fill) % (1 << W);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mo[d] = 0; mrem[d] = 0; mbusy[d] = 0; mdone[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int lo_bit, hi_bit, fr, fl;
            lo_bit = mo[d] % 2;
            hi_bit = mo[d] / (1 << (W - 1));
            fr = (rot_on() != 0) ? lo_bit : int'(Is);
            fl = (rot_on() != 0) ? hi_bit : int'(Is);
            mdone[d] = 0;
            if (CLR) begin
                mo[d] = 0; mrem[d] = 0; mbusy[d] = 0;
            end else if (CE) begin
                if (!mbusy[d]) begin
                    if (START) begin
                        mo[d] = int'(Ip); mrem[d] = W; mbusy[d] = 1;
                    end else if (M == 2'b01) mo[d] = sh_right(mo[d], fr);
                    else if (M == 2'b10) mo[d] = sh_left(mo[d], fl);
                    else if (M == 2'b11) mo[d] = int'(Ip);
                end else begin
                    mo[d] = (d == 0) ? sh_right(mo[d], fr) : sh_left(mo[d], fl);
                    mrem[d] = mrem[d] - 1;
                    if (mrem[d] == 0) begin
                        mbusy[d] = 0; mdone[d] = 1;
                    end
                end
            end
        end
    endtask

    // one falling edge of C, model advanced with the same inputs, sampled 1 after
    task automatic tick();
        @(negedge C);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        nvec++; if (O0 !== 4'b0000) begin nerr++; $display("FAIL reset_O got %b want 0000", O0); end
        nvec++; if (So0 !== 1'b0) begin nerr++; $display("FAIL reset_So got %b want 0", So0); end
        nvec++; if (B0 !== 1'b0 || B1 !== 1'b0) begin nerr++; $display("FAIL reset_BUSY got %b%b want 00", B0, B1); end
        nvec++; if (D0 !== 1'b0 || D1 !== 1'b0) begin nerr++; $display("FAIL reset_DONE got %b%b want 00", D0, D1); end
        CLR = 1'b0;
        model_reset();
        CE = 1'b1; M = 2'b11; Ip = 4'b1011;
        tick();
        nvec++; if (O0 !== 4'b1011) begin nerr++; $display("FAIL preload got %b want 1011", O0); end
        M = 2'b00;
        #2 CLR = 1'b1;
        #1;
        model_reset();
        nvec++; if (O0 !== 4'b0000 || O1 !== 4'b0000) begin nerr++; $display("FAIL async_clr_O got %b/%b want 0000", O0, O1); end
        nvec++; if (B0 !== 1'b0 || D0 !== 1'b0) begin nerr++; $display("FAIL async_clr_ctl got %b%b want 00", B0, D0); end
        CLR = 1'b0;
    endtask

    task automatic test_modes();
        CE = 1'b1; START = 1'b0; M = 2'b11; Ip = 4'b1101;
        tick();
        nvec++; if (O0 !== 4'b1101) begin nerr++; $display("FAIL load got %b want 1101", O0); end
        M = 2'b01; Is = 1'b0;
        tick();
        nvec++; if (O0 !== 4'b0110) begin nerr++; $display("FAIL shr1 got %b want 0110", O0); end
        tick();
        nvec++; if (O0 !== 4'b0011) begin nerr++; $display("FAIL shr2 got %b want 0011", O0); end
        M = 2'b10; Is = 1'b1;
        tick();
        nvec++; if (O0 !== 4'b0111) begin nerr++; $display("FAIL shl1 got %b want 0111", O0); end
        tick();
        nvec++; if (O0 !== 4'b1111) begin nerr++; $display("FAIL shl2 got %b want 1111", O0); end
        M = 2'b00; Ip = 4'b0101;
        tick();
        nvec++; if (O0 !== 4'b1111) begin nerr++; $display("FAIL hold got %b want 1111", O0); end
    endtask

    task automatic test_ce_hold();
        CE = 1'b0; M = 2'b11; Ip = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++; if (O0 !== 4'b1111 || D0 !== 1'b0) begin nerr++; $display("FAIL ce_hold O=%b DONE=%b want 1111/0", O0, D0); end
        end
        CE = 1'b1; M = 2'b00;
    endtask

    // LSB-first and MSB-first transfers run side by side; optional 2-clock CE stall
    task automatic test_xfer(input bit stall);
        logic [W-1:0] pat;
        pat = 4'b1101;
        CE = 1'b1; Is = 1'b0; Ip = pat; M = 2'b01; START = 1'b1;
        tick();
        START = 1'b0; Ip = 4'b0000;
        for (int k = 0; k < W; k++) begin
            nvec++; if (So0 !== pat[k]) begin nerr++; $display("FAIL xfer_lsb_So k=%0d got %b want %b", k, So0, pat[k]); end
            nvec++; if (So1 !== pat[W-1-k]) begin nerr++; $display("FAIL xfer_msb_So k=%0d got %b want %b", k, So1, pat[W-1-k]); end
            nvec++; if (B0 !== 1'b1 || B1 !== 1'b1 || D0 !== 1'b0) begin nerr++; $display("FAIL xfer_busy k=%0d BUSY=%b%b DONE=%b want 11/0", k, B0, B1, D0); end
            if (stall && k == 2) begin
                CE = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    nvec++; if (So0 !== pat[k] || B0 !== 1'b1 || D0 !== 1'b0) begin nerr++; $display("FAIL stall So=%b BUSY=%b DONE=%b want %b/1/0", So0, B0, D0, pat[k]); end
                end
                CE = 1'b1;
            end
            tick();
        end
        nvec++; if (D0 !== 1'b1 || D1 !== 1'b1) begin nerr++; $display("FAIL xfer_done got %b%b want 11", D0, D1); end
        nvec++; if (B0 !== 1'b0 || O0 !== 4'b0000 || O1 !== 4'b0000) begin nerr++; $display("FAIL xfer_end BUSY=%b O=%b/%b want 0/0000", B0, O0, O1); end
        M = 2'b00;
        tick();
        nvec++; if (D0 !== 1'b0 || B0 !== 1'b0) begin nerr++; $display("FAIL done_pulse DONE=%b BUSY=%b want 0/0", D0, B0); end
    endtask

    task automatic test_xfer_abort();
        CE = 1'b1; Is = 1'b0; Ip = 4'b1101; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick();
        nvec++; if (O0 !== 4'b0011 || B0 !== 1'b1) begin nerr++; $display("FAIL abort_pre O=%b BUSY=%b want 0011/1", O0, B0); end
        #2 CLR = 1'b1;
        #1;
        model_reset();
        nvec++; if (O0 !== 4'b0000 || B0 !== 1'b0 || B1 !== 1'b0) begin nerr++; $display("FAIL abort_clr O=%b BUSY=%b%b want 0000/00", O0, B0, B1); end
        CLR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++; if (D0 !== 1'b0 || B0 !== 1'b0) begin nerr++; $display("FAIL abort_after DONE=%b BUSY=%b want 0/0", D0, B0); end
        end
    endtask

    // START held high through the transfer, then re-arms right after DONE
    task automatic test_start_held();
        logic [W-1:0] pat;
        pat = 4'b1101;
        CE = 1'b1; Is = 1'b0; Ip = pat; START = 1'b1;
        tick();
        for (int k = 0; k < W; k++) begin
            nvec++; if (So1 !== pat[W-1-k] || B1 !== 1'b1) begin nerr++; $display("FAIL held_msb k=%0d So=%b BUSY=%b want %b/1", k, So1, B1, pat[W-1-k]); end
            tick();
        end
        nvec++; if (D1 !== 1'b1 || O1 !== 4'b0000) begin nerr++; $display("FAIL held_done DONE=%b O=%b want 1/0000", D1, O1); end
        tick();
        nvec++; if (B1 !== 1'b1 || O1 !== pat || D1 !== 1'b0) begin nerr++; $display("FAIL rearm BUSY=%b O=%b DONE=%b want 1/%b/0", B1, O1, D1, pat); end
        START = 1'b0;
        #2 CLR = 1'b1;
        #1;
        model_reset();
        CLR = 1'b0;
    endtask

`ifdef SHREG_ROTATE_EN
    task automatic test_rotate();
        CE = 1'b1; ROT = 1'b0; M = 2'b11; Ip = 4'b1101; Is = 1'b0;
        tick();
        ROT = 1'b1; M = 2'b01;
        tick();
        nvec++; if (O0 !== 4'b1110) begin nerr++; $display("FAIL rot1 got %b want 1110", O0); end
        tick();
        nvec++; if (O0 !== 4'b0111) begin nerr++; $display("FAIL rot2 got %b want 0111", O0); end
        M = 2'b00; Ip = 4'b1001; START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < W; k++) tick();
        nvec++; if (D0 !== 1'b1 || O0 !== 4'b1001 || O1 !== 4'b1001) begin nerr++; $display("FAIL rot_xfer DONE=%b O=%b/%b want 1/1001", D0, O0, O1); end
        ROT = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            CE    = ($urandom_range(0, 3) != 0);
            M     = 2'($urandom_range(0, 3));
            Is    = 1'($urandom_range(0, 1));
            Ip    = 4'($urandom_range(0, 15));
            START = ($urandom_range(0, 4) == 0);
            ROT   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) begin
                CLR = 1'b1;
                #1;
                model_reset();
                nvec++; if (O0 !== 4'b0000 || B1 !== 1'b0) begin nerr++; $display("FAIL rnd_clr O=%b BUSY=%b want 0000/0", O0, B1); end
                CLR = 1'b0;
            end
            tick();
            nvec++; if (O0 !== 4'(mo[0])) begin nerr++; $display("FAIL rnd_O_lsb n=%0d got %b want %b", n, O0, 4'(mo[0])); end
            nvec++; if (O1 !== 4'(mo[1])) begin nerr++; $display("FAIL rnd_O_msb n=%0d got %b want %b", n, O1, 4'(mo[1])); end
            nvec++; if (So0 !== 1'(mo[0] % 2)) begin nerr++; $display("FAIL rnd_So_lsb n=%0d got %b want %0d", n, So0, mo[0] % 2); end
            nvec++; if (So1 !== 1'(mo[1] / (1 << (W - 1)))) begin nerr++; $display("FAIL rnd_So_msb n=%0d got %b want %0d", n, So1, mo[1] / (1 << (W - 1))); end
            nvec++; if (B0 !== mbusy[0] || B1 !== mbusy[1]) begin nerr++; $display("FAIL rnd_BUSY n=%0d got %b%b want %b%b", n, B0, B1, mbusy[0], mbusy[1]); end
            nvec++; if (D0 !== mdone[0] || D1 !== mdone[1]) begin nerr++; $display("FAIL rnd_DONE n=%0d got %b%b want %b%b", n, D0, D1, mdone[0], mdone[1]); end
        end
        START = 1'b0; ROT = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_modes();
        test_ce_hold();
        test_xfer(1'b0);
        test_xfer(1'b1);
        test_xfer_abort();
        test_start_held();
`ifdef SHREG_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
